sr_cmd_debouncer: RTL and testbench

- Upstream command stage for the SR flip-flop.
- Takes two raw, asynchronous push-button inputs (set request, reset request). Synchronizes and debounces each one.
- Turns each debounced press into a fixed-width pulse on S or R.
- Guarantees the forbidden S=R=1 combination is never presented downstream.
- Outputs drive the flip-flop's S and R inputs directly, on the same CLK.

---
 rtl/sr_cmd_pkg.sv | 15 +
 rtl/sr_btn_debounce.sv | 54 +++++
 rtl/sr_cmd_debouncer.sv | 136 +++++++++++++
 tb/tb_sr_cmd_debouncer.sv | 375 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_cmd_pkg.sv
// sr_cmd_pkg: shared state encoding and default timing constants for the
// SR flip-flop command front end.
package sr_cmd_pkg;

  localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
  localparam int unsigned DEF_PULSE_CYCLES    = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRIVE_S = 2'd1,
    ST_DRIVE_R = 2'd2,
    ST_HOLDOFF = 2'd3
  } sr_state_e;

endpackage

// File: rtl/sr_btn_debounce.sv
// sr_btn_debounce: two-flop synchronizer, stability counter and rising-edge
// detect for one raw push-button. rise is a one-cycle registered pulse on each
// debounced 0->1 transition; releases produce nothing.
module sr_btn_debounce
  import sr_cmd_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_W           = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q1;
  logic             sync_q2;
  logic             level_q;
  logic [CNT_W-1:0] cnt_q;

  // Bring the asynchronous button into the clock domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q1 <= btn;
      sync_q2 <= sync_q1;
    end
  end

  // Debounced level flips only after DEBOUNCE_CYCLES consecutive differing samples
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= 1'b0;
      cnt_q   <= '0;
      rise    <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (sync_q2 == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        level_q <= sync_q2;
        cnt_q   <= '0;
        rise    <= sync_q2;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sr_cmd_debouncer.sv
// sr_cmd_debouncer: debounces the set/reset buttons and issues fixed-width,
// mutually exclusive S/R pulses to the downstream SR flip-flop.
// Build option SR_CMD_RESET_PRIORITY_EN: when both requests are pending at
// once, serve the reset first and keep the set queued; otherwise drop both.
module sr_cmd_debouncer
  import sr_cmd_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int unsigned PULSE_CYCLES    = DEF_PULSE_CYCLES,
  parameter int unsigned CNT_W           = 16
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic BTN_SET,
  input  logic BTN_RST,
  output logic S,
  output logic R,
  output logic BUSY,
  output logic CONFLICT
);

  localparam logic [7:0] PULSE_LAST = 8'(PULSE_CYCLES - 1);

  sr_state_e  state_q;
  logic [7:0] pcnt_q;
  logic       rise_s;
  logic       rise_r;
  logic       pend_s;
  logic       pend_r;
  logic       take_s;
  logic       take_r;
  logic       clr_s;
  logic       clr_r;
  logic       conflict_now;

  sr_btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_deb_set (
    .clk   (CLK),
    .rst_n (RST_N),
    .btn   (BTN_SET),
    .rise  (rise_s)
  );

  sr_btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_deb_rst (
    .clk   (CLK),
    .rst_n (RST_N),
    .btn   (BTN_RST),
    .rise  (rise_r)
  );

  // Decide which pending request is accepted this cycle and which flags clear
  always_comb begin
    take_s       = 1'b0;
    take_r       = 1'b0;
    clr_s        = 1'b0;
    clr_r        = 1'b0;
    conflict_now = 1'b0;
    if (state_q == ST_IDLE || state_q == ST_HOLDOFF) begin
      if (pend_s && pend_r) begin
        conflict_now = 1'b1;
`ifdef SR_CMD_RESET_PRIORITY_EN
        take_r = 1'b1;
        clr_r  = 1'b1;
`else
        clr_s  = 1'b1;
        clr_r  = 1'b1;
`endif
      end else if (pend_s) begin
        take_s = 1'b1;
        clr_s  = 1'b1;
      end else if (pend_r) begin
        take_r = 1'b1;
        clr_r  = 1'b1;
      end
    end
  end

  // Pending flags: a new debounced edge always sets (wins over a same-cycle clear)
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pend_s <= 1'b0;
      pend_r <= 1'b0;
    end else begin
      pend_s <= rise_s | (pend_s & ~clr_s);
      pend_r <= rise_r | (pend_r & ~clr_r);
    end
  end

  // Pulse FSM with registered S/R/BUSY/CONFLICT.
  // HOLDOFF exits through the same acceptance as IDLE so a queued request
  // starts right after the single S=R=0 cycle without BUSY dropping.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      pcnt_q   <= '0;
      S        <= 1'b0;
      R        <= 1'b0;
      BUSY     <= 1'b0;
      CONFLICT <= 1'b0;
    end else begin
      CONFLICT <= conflict_now;
      case (state_q)
        ST_IDLE, ST_HOLDOFF: begin
          pcnt_q <= PULSE_LAST;
          S      <= take_s;
          R      <= take_r;
          BUSY   <= take_s | take_r;
          if (take_s)      state_q <= ST_DRIVE_S;
          else if (take_r) state_q <= ST_DRIVE_R;
          else             state_q <= ST_IDLE;
        end
        ST_DRIVE_S, ST_DRIVE_R: begin
          if (pcnt_q == '0) begin
            state_q <= ST_HOLDOFF;
            S       <= 1'b0;
            R       <= 1'b0;
          end else begin
            pcnt_q <= pcnt_q - 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          S       <= 1'b0;
          R       <= 1'b0;
          BUSY    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sr_cmd_debouncer.sv
// tb_sr_cmd_debouncer: scenario tasks plus randomized traffic, each cycle
// checked against a time-indexed behavioural model of the command front end.
module tb_sr_cmd_debouncer;

  localparam int D    = 4;
  localparam int P    = 2;
  localparam int RING = 64;

  logic CLK, RST_N, BTN_SET, BTN_RST;
  logic S, R, BUSY, CONFLICT;

  int n_cmp = 0;
  int n_err = 0;

  sr_cmd_debouncer #(
    .DEBOUNCE_CYCLES (D),
    .PULSE_CYCLES    (P),
    .CNT_W           (16)
  ) dut (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .BTN_SET  (BTN_SET),
    .BTN_RST  (BTN_RST),
    .S        (S),
    .R        (R),
    .BUSY     (BUSY),
    .CONFLICT (CONFLICT)
  );

  initial begin
    CLK = 1'b0;
    forever #10 CLK = ~CLK;
  end

  // ---------------- reference model ----------------
  // Edge-indexed: button history by edge number, debounced level flips when
  // the synchronized view has differed for D edges in a row, requests are
  // scheduled as whole pulses into an output timeline.
  int   cyc = 0;
  int   rel_cyc = 0;
  int   free_at = 0;
  logic btn_hist [2][RING];
  logic es [RING];
  logic er [RING];
  logic eb [RING];
  logic deb [2];
  logic last_seen [2];
  logic rise_prev [2];
  logic pend [2];
  int   run_start [2];
  logic x_s, x_r, x_b, x_c;

  function automatic void model_clear();
    for (int i = 0; i < RING; i++) begin
      es[i] = 1'b0; er[i] = 1'b0; eb[i] = 1'b0;
    end
    for (int c = 0; c < 2; c++) begin
      deb[c] = 1'b0; last_seen[c] = 1'b0; rise_prev[c] = 1'b0;
      pend[c] = 1'b0; run_start[c] = 0;
    end
    free_at = 0;
    rel_cyc = cyc + 1;
    x_s = 1'b0; x_r = 1'b0; x_b = 1'b0; x_c = 1'b0;
  endfunction

  function automatic void sched(input int ch);
    for (int i = 0; i < P; i++) begin
      if (ch == 0) es[(cyc + i) % RING] = 1'b1;
      else         er[(cyc + i) % RING] = 1'b1;
    end
    for (int i = 0; i <= P; i++) eb[(cyc + i) % RING] = 1'b1;
    free_at = cyc + P + 1;
  endfunction

  function automatic void model_edge(input logic bs, input logic br);
    logic seen;
    int   slot;
    if (RST_N !== 1'b1) begin
      model_clear();
      cyc++;
      return;
    end
    slot = cyc % RING;
    btn_hist[0][slot] = bs;
    btn_hist[1][slot] = br;
    x_c = 1'b0;
    if (cyc >= free_at) begin
      if (pend[0] && pend[1]) begin
        x_c = 1'b1;
`ifdef SR_CMD_RESET_PRIORITY_EN
        sched(1);
        pend[1] = 1'b0;
`else
        pend[0] = 1'b0;
        pend[1] = 1'b0;
`endif
      end else if (pend[0]) begin
        sched(0);
        pend[0] = 1'b0;
      end else if (pend[1]) begin
        sched(1);
        pend[1] = 1'b0;
      end
    end
    for (int c = 0; c < 2; c++) begin
      pend[c] = pend[c] | rise_prev[c];
      seen = (cyc - 2 >= rel_cyc) ? btn_hist[c][(cyc - 2) % RING] : 1'b0;
      if (seen != last_seen[c]) run_start[c] = cyc;
      last_seen[c] = seen;
      rise_prev[c] = 1'b0;
      if (seen != deb[c] && (cyc - run_start[c] + 1) >= D) begin
        deb[c]       = seen;
        rise_prev[c] = seen;
      end
    end
    x_s = es[slot]; x_r = er[slot]; x_b = eb[slot];
    es[slot] = 1'b0; er[slot] = 1'b0; eb[slot] = 1'b0;
    cyc++;
  endfunction

  task automatic step(input logic bs, input logic br);
    BTN_SET = bs;
    BTN_RST = br;
    @(posedge CLK);
    model_edge(bs, br);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    int first_s = -1;
    int s_cnt   = 0;
    RST_N = 1'b0;
    model_clear();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0);
      n_cmp++;
      if ({S, R, BUSY, CONFLICT} !== 4'b0000) begin
        n_err++;
        $display("FAIL reset_hold i=%0d got SRBC=%b want 0000", i, {S, R, BUSY, CONFLICT});
      end
    end
    RST_N = 1'b1;
    for (int i = 0; i < 25; i++) begin
      step(i < 12, 1'b0);
      n_cmp++;
      if ({S, R, BUSY, CONFLICT} !== {x_s, x_r, x_b, x_c}) begin
        n_err++;
        $display("FAIL reset_exit i=%0d got SRBC=%b want %b", i, {S, R, BUSY, CONFLICT}, {x_s, x_r, x_b, x_c});
      end
      if (S === 1'b1) begin
        s_cnt++;
        if (first_s < 0) first_s = i;
      end
    end
    n_cmp++;
    if (first_s != D + 3) begin
      n_err++;
      $display("FAIL reset_latency got %0d want %0d", first_s, D + 3);
    end
    n_cmp++;
    if (s_cnt != P) begin
      n_err++;
      $display("FAIL reset_width got %0d want %0d", s_cnt, P);
    end
  endtask

  task automatic test_bounce();
    int   s_rises = 0, s_high = 0, r_high = 0, c_cnt = 0;
    logic prev_s  = 1'b0;
    logic bs;
    for (int i = 0; i < 50; i++) begin
      bs = (i < 10) ? (((i / 2) % 2) == 0) : (i < 30);
      step(bs, 1'b0);
      n_cmp++;
      if ({S, R, BUSY, CONFLICT} !== {x_s, x_r, x_b, x_c}) begin
        n_err++;
        $display("FAIL bounce i=%0d got SRBC=%b want %b", i, {S, R, BUSY, CONFLICT}, {x_s, x_r, x_b, x_c});
      end
      if (S === 1'b1 && prev_s !== 1'b1) s_rises++;
      if (S === 1'b1) s_high++;
      if (R === 1'b1) r_high++;
      if (CONFLICT === 1'b1) c_cnt++;
      prev_s = S;
    end
    n_cmp++;
    if (s_rises != 1 || s_high != P || r_high != 0 || c_cnt != 0) begin
      n_err++;
      $display("FAIL bounce_pulses got rises=%0d s=%0d r=%0d c=%0d want 1/%0d/0/0",
               s_rises, s_high, r_high, c_cnt, P);
    end
  endtask

  task automatic test_sequence();
    int s_last = -1, r_first = -1, s_high = 0, r_high = 0;
    for (int i = 0; i < 45; i++) begin
      step(i < 10, (i >= 15) && (i < 25));
      n_cmp++;
      if ({S, R, BUSY, CONFLICT} !== {x_s, x_r, x_b, x_c}) begin
        n_err++;
        $display("FAIL sequence i=%0d got SRBC=%b want %b", i, {S, R, BUSY, CONFLICT}, {x_s, x_r, x_b, x_c});
      end
      if (S === 1'b1) begin s_high++; s_last = i; end
      if (R === 1'b1) begin r_high++; if (r_first < 0) r_first = i; end
    end
    n_cmp++;
    if (s_high != P || r_high != P || s_last < 0 || r_first - s_last < 2) begin
      n_err++;
      $display("FAIL sequence_order got s=%0d r=%0d s_last=%0d r_first=%0d want %0d/%0d gap>=2",
               s_high, r_high, s_last, r_first, P, P);
    end
  endtask

  task automatic test_busy_queue();
    int s_first = -1, s_last = -1, r_first = -1, r_last = -1;
    int busy_trace [40];
    int busy_gaps = 0;
    for (int i = 0; i < 35; i++) begin
      step(i < 12, (i >= 1) && (i < 13));
      n_cmp++;
      if ({S, R, BUSY, CONFLICT} !== {x_s, x_r, x_b, x_c}) begin
        n_err++;
        $display("FAIL busy_queue i=%0d got SRBC=%b want %b", i, {S, R, BUSY, CONFLICT}, {x_s, x_r, x_b, x_c});
      end
      busy_trace[i] = (BUSY === 1'b1) ? 1 : 0;
      if (S === 1'b1) begin if (s_first < 0) s_first = i; s_last = i; end
      if (R === 1'b1) begin if (r_first < 0) r_first = i; r_last = i; end
    end
    n_cmp++;
    if (s_last < 0 || r_first - s_last != 2) begin
      n_err++;
      $display("FAIL busy_queue_gap got s_last=%0d r_first=%0d want r_first=s_last+2", s_last, r_first);
    end
    if (s_first >= 0 && r_last >= 0) begin
      for (int i = s_first; i <= r_last; i++) if (busy_trace[i] == 0) busy_gaps++;
    end
    n_cmp++;
    if (s_first < 0 || r_last < 0 || busy_gaps != 0) begin
      n_err++;
      $display("FAIL busy_queue_busy got gaps=%0d s_first=%0d r_last=%0d want 0 gaps", busy_gaps, s_first, r_last);
    end
  endtask

  task automatic test_simultaneous();
    int c_cnt = 0, s_high = 0, r_high = 0, b_cnt = 0;
    int s_first = -1, r_last = -1;
    for (int i = 0; i < 35; i++) begin
      step(i < 12, i < 12);
      n_cmp++;
      if ({S, R, BUSY, CONFLICT} !== {x_s, x_r, x_b, x_c}) begin
        n_err++;
        $display("FAIL simultaneous i=%0d got SRBC=%b want %b", i, {S, R, BUSY, CONFLICT}, {x_s, x_r, x_b, x_c});
      end
      if (CONFLICT === 1'b1) c_cnt++;
      if (BUSY === 1'b1) b_cnt++;
      if (S === 1'b1) begin s_high++; if (s_first < 0) s_first = i; end
      if (R === 1'b1) begin r_high++; r_last = i; end
    end
    n_cmp++;
    if (c_cnt != 1) begin
      n_err++;
      $display("FAIL simultaneous_conflict got %0d want 1", c_cnt);
    end
`ifdef SR_CMD_RESET_PRIORITY_EN
    n_cmp++;
    if (s_high != P || r_high != P || s_first - r_last != 2) begin
      n_err++;
      $display("FAIL simultaneous_order got s=%0d r=%0d r_last=%0d s_first=%0d want R then S after holdoff",
               s_high, r_high, r_last, s_first);
    end
`else
    n_cmp++;
    if (s_high != 0 || r_high != 0 || b_cnt != 0) begin
      n_err++;
      $display("FAIL simultaneous_drop got s=%0d r=%0d busy=%0d want 0/0/0", s_high, r_high, b_cnt);
    end
`endif
  endtask

  task automatic test_mid_reset();
    logic found = 1'b0;
    int   s_high = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(1'b1, 1'b0);
      n_cmp++;
      if ({S, R, BUSY, CONFLICT} !== {x_s, x_r, x_b, x_c}) begin
        n_err++;
        $display("FAIL mid_reset_pre i=%0d got SRBC=%b want %b", i, {S, R, BUSY, CONFLICT}, {x_s, x_r, x_b, x_c});
      end
      if (S === 1'b1) found = 1'b1;
    end
    n_cmp++;
    if (!found) begin
      n_err++;
      $display("FAIL mid_reset_wait got no S within 20 cycles want S pulse");
    end
    #2;
    RST_N   = 1'b0;
    BTN_SET = 1'b0;
    model_clear();
    #1;
    n_cmp++;
    if ({S, R, BUSY, CONFLICT} !== 4'b0000) begin
      n_err++;
      $display("FAIL mid_reset_async got SRBC=%b want 0000", {S, R, BUSY, CONFLICT});
    end
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    #2;
    RST_N = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0);
      n_cmp++;
      if ({S, R, BUSY, CONFLICT} !== {x_s, x_r, x_b, x_c}) begin
        n_err++;
        $display("FAIL mid_reset_post i=%0d got SRBC=%b want %b", i, {S, R, BUSY, CONFLICT}, {x_s, x_r, x_b, x_c});
      end
      if (S === 1'b1) s_high++;
    end
    n_cmp++;
    if (s_high != 0) begin
      n_err++;
      $display("FAIL mid_reset_replay got %0d S cycles want 0", s_high);
    end
  endtask

  task automatic test_random();
    logic bs = 1'b0, br = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 5) == 0) bs = ~bs;
      if ($urandom_range(0, 5) == 0) br = ~br;
      step(bs, br);
      n_cmp++;
      if ({S, R, BUSY, CONFLICT} !== {x_s, x_r, x_b, x_c}) begin
        n_err++;
        $display("FAIL random i=%0d got SRBC=%b want %b", i, {S, R, BUSY, CONFLICT}, {x_s, x_r, x_b, x_c});
      end
      n_cmp++;
      if ((S & R) !== 1'b0) begin
        n_err++;
        $display("FAIL random_exclusive i=%0d got S=%b R=%b want not both high", i, S, R);
      end
    end
    for (int i = 0; i < 20; i++) begin
      step(1'b0, 1'b0);
      n_cmp++;
      if ({S, R, BUSY, CONFLICT} !== {x_s, x_r, x_b, x_c}) begin
        n_err++;
        $display("FAIL random_tail i=%0d got SRBC=%b want %b", i, {S, R, BUSY, CONFLICT}, {x_s, x_r, x_b, x_c});
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got no finish want completion within 2 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    RST_N   = 1'b0;
    BTN_SET = 1'b1;
    BTN_RST = 1'b0;
    test_reset();
    test_bounce();
    test_sequence();
    test_busy_queue();
    test_simultaneous();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
